// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the 5-stage 16-bit pipeline control.
//   REG_AW       register address width, shared with the pipe registers
//   MEM_TIMEOUT  wait cycles without dmem_ack before the controller gives up
//   CNT_W        width of the stall counter
//   ctrl_state_t hazard controller states
//   fwd_sel_t    EX operand source select
package cpu_pipe_pkg;

  localparam int REG_AW      = 5;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of everything the hazard controller sees from and drives into the pipe.
//   master : the hazard controller (reads stage info, drives enables/flushes/fwd/dmem_req)
//   slave  : the pipeline side (drives stage info, reads the controls)
interface pipe_hazard_ctrl_if
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW = cpu_pipe_pkg::REG_AW,
  parameter int CNT_W  = cpu_pipe_pkg::CNT_W
);

  logic [REG_AW-1:0] id_ra1, id_ra2;
  logic              id_use1, id_use2;
  logic [REG_AW-1:0] ex_ra1, ex_ra2, ex_wa;
  logic              ex_we, ex_load;
  logic [REG_AW-1:0] mem_wa;
  logic              mem_we;
  logic [REG_AW-1:0] wb_wa;
  logic              wb_we;
  logic              br_taken;
  logic              mem_acc;
  logic              dmem_ack;

  logic              en_if, en_id, en_ex, en_mem;
  logic              flush_id, flush_ex;
  fwd_sel_t          fwd_a, fwd_b;
  logic              dmem_req;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    input  id_ra1, id_ra2, id_use1, id_use2,
    input  ex_ra1, ex_ra2, ex_wa, ex_we, ex_load,
    input  mem_wa, mem_we, wb_wa, wb_we,
    input  br_taken, mem_acc, dmem_ack,
    output en_if, en_id, en_ex, en_mem,
    output flush_id, flush_ex,
    output fwd_a, fwd_b,
    output dmem_req, mem_timeout, stall_cnt
  );

  modport slave (
    output id_ra1, id_ra2, id_use1, id_use2,
    output ex_ra1, ex_ra2, ex_wa, ex_we, ex_load,
    output mem_wa, mem_we, wb_wa, wb_we,
    output br_taken, mem_acc, dmem_ack,
    input  en_if, en_id, en_ex, en_mem,
    input  flush_id, flush_ex,
    input  fwd_a, fwd_b,
    input  dmem_req, mem_timeout, stall_cnt
  );

endinterface

// File: rtl/pipe_fwd_unit.sv
// Forwarding select for one EX source operand.
//   ex_ra          source register read by the instruction in EX
//   mem_wa/mem_we  destination of the instruction in MEM
//   wb_wa/wb_we    destination of the instruction in WB
//   sel            FWD_MEM, FWD_WB or FWD_RF; MEM is younger so it wins, r0 never forwards
module pipe_fwd_unit
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW = cpu_pipe_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] ex_ra,
  input  logic [REG_AW-1:0] mem_wa,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic              wb_we,
  output fwd_sel_t          sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_we && (mem_wa != '0) && (mem_wa == ex_ra)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_wa != '0) && (wb_wa == ex_ra)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers.
// Drives stage enables and bubble flushes, detects load-use hazards, selects EX
// operand forwarding and freezes the pipe while data memory is outstanding.
//   clk  rising-edge clock
//   rst  asynchronous reset, active low
//   bus  pipe_hazard_ctrl_if.master (stage info in, pipe controls out)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | pipe advances; branch/load-use handled; dmem_req = mem_acc
//   MEM_WAIT | whole pipe frozen until dmem_ack, counting wait cycles
//   ERR      | memory never answered; pipe frozen, mem_timeout up until reset
module pipe_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW      = cpu_pipe_pkg::REG_AW,
  parameter int MEM_TIMEOUT = cpu_pipe_pkg::MEM_TIMEOUT,
  parameter int CNT_W       = cpu_pipe_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.master  bus
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              started_q;
  logic [CNT_W-1:0]  stall_q;

  fwd_sel_t fwd_a_raw, fwd_b_raw;
  logic     load_use;
  logic     freeze;
  logic     req;
  logic     en_if, en_id, en_ex, en_mem;
  logic     flush_id, flush_ex;

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_ra  (bus.ex_ra1),
    .mem_wa (bus.mem_wa),
    .mem_we (bus.mem_we),
    .wb_wa  (bus.wb_wa),
    .wb_we  (bus.wb_we),
    .sel    (fwd_a_raw)
  );

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_ra  (bus.ex_ra2),
    .mem_wa (bus.mem_wa),
    .mem_we (bus.mem_we),
    .wb_wa  (bus.wb_wa),
    .wb_we  (bus.wb_we),
    .sel    (fwd_b_raw)
  );

  assign load_use = bus.ex_load && bus.ex_we && (bus.ex_wa != '0) &&
                    ((bus.id_use1 && (bus.id_ra1 == bus.ex_wa)) ||
                     (bus.id_use2 && (bus.id_ra2 == bus.ex_wa)));

  // started_q holds every output quiet until the first clock after reset release.
  // The dmem_ack cycle in MEM_WAIT is treated as an unfrozen cycle, so a branch or
  // load-use sitting in the frozen EX/ID stages is acted on as the pipe resumes.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    freeze  = 1'b1;
    req     = 1'b0;
    if (started_q) begin
      unique case (state_q)
        RUN: begin
          req    = bus.mem_acc;
          freeze = bus.mem_acc && !bus.dmem_ack;
          if (freeze) begin
            state_d = MEM_WAIT;
            wcnt_d  = '0;
          end
        end
        MEM_WAIT: begin
          req = 1'b1;
          if (bus.dmem_ack) begin
            freeze  = 1'b0;
            state_d = RUN;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
            if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
              state_d = ERR;
            end
          end
        end
        default: begin
          state_d = ERR;
        end
      endcase
    end

    en_if    = 1'b0;
    en_id    = 1'b0;
    en_ex    = 1'b0;
    en_mem   = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (!freeze) begin
      en_ex  = 1'b1;
      en_mem = 1'b1;
      if (bus.br_taken) begin
        en_if    = 1'b1;
        en_id    = 1'b1;
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        flush_ex = 1'b1;
      end else begin
        en_if = 1'b1;
        en_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      started_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      started_q <= 1'b1;
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      if (!en_if && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign bus.en_if       = en_if;
  assign bus.en_id       = en_id;
  assign bus.en_ex       = en_ex;
  assign bus.en_mem      = en_mem;
  assign bus.flush_id    = flush_id;
  assign bus.flush_ex    = flush_ex;
  assign bus.fwd_a       = started_q ? fwd_a_raw : FWD_RF;
  assign bus.fwd_b       = started_q ? fwd_b_raw : FWD_RF;
  assign bus.dmem_req    = req;
  assign bus.mem_timeout = (state_q == ERR);
  assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  import cpu_pipe_pkg::*;

  typedef struct {
    logic [REG_AW-1:0] id_ra1, id_ra2;
    logic              id_use1, id_use2;
    logic [REG_AW-1:0] ex_ra1, ex_ra2, ex_wa;
    logic              ex_we, ex_load;
    logic [REG_AW-1:0] mem_wa;
    logic              mem_we;
    logic [REG_AW-1:0] wb_wa;
    logic              wb_we;
    logic              br_taken, mem_acc, dmem_ack;
  } stim_t;

  typedef struct {
    logic [3:0]  en;   // {en_if, en_id, en_ex, en_mem}
    logic [1:0]  fl;   // {flush_id, flush_ex}
    logic [1:0]  fa, fb;
    logic        req, to;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model state: pipeline started, access outstanding, timed out, waits, stalls
  bit m_started, m_busy, m_err;
  int m_waits, m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [REG_AW-1:0] ra, input stim_t s);
    if (s.mem_we && s.mem_wa != 0 && s.mem_wa == ra) return 2'b01;
    if (s.wb_we && s.wb_wa != 0 && s.wb_wa == ra) return 2'b10;
    return 2'b00;
  endfunction

  function automatic stim_t zero_stim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.id_ra1   = REG_AW'($urandom_range(0, 3));
    s.id_ra2   = REG_AW'($urandom_range(0, 3));
    s.id_use1  = 1'($urandom_range(0, 1));
    s.id_use2  = 1'($urandom_range(0, 1));
    s.ex_ra1   = REG_AW'($urandom_range(0, 3));
    s.ex_ra2   = REG_AW'($urandom_range(0, 3));
    s.ex_wa    = REG_AW'($urandom_range(0, 3));
    s.ex_we    = 1'($urandom_range(0, 1));
    s.ex_load  = ($urandom_range(0, 2) == 0);
    s.mem_wa   = REG_AW'($urandom_range(0, 3));
    s.mem_we   = 1'($urandom_range(0, 1));
    s.wb_wa    = REG_AW'($urandom_range(0, 3));
    s.wb_we    = 1'($urandom_range(0, 1));
    s.br_taken = ($urandom_range(0, 7) == 0);
    s.mem_acc  = ($urandom_range(0, 3) == 0);
    s.dmem_ack = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.id_ra1   = s.id_ra1;
    bus.id_ra2   = s.id_ra2;
    bus.id_use1  = s.id_use1;
    bus.id_use2  = s.id_use2;
    bus.ex_ra1   = s.ex_ra1;
    bus.ex_ra2   = s.ex_ra2;
    bus.ex_wa    = s.ex_wa;
    bus.ex_we    = s.ex_we;
    bus.ex_load  = s.ex_load;
    bus.mem_wa   = s.mem_wa;
    bus.mem_we   = s.mem_we;
    bus.wb_wa    = s.wb_wa;
    bus.wb_we    = s.wb_we;
    bus.br_taken = s.br_taken;
    bus.mem_acc  = s.mem_acc;
    bus.dmem_ack = s.dmem_ack;
  endtask

  // One clock of stimulus: predict outputs, queue them for the monitor, advance the model.
  task automatic step(input stim_t s, input bit chk);
    exp_t e;
    bit   lu, froz;
    apply(s);
    lu = s.ex_load && s.ex_we && s.ex_wa != 0 &&
         ((s.id_use1 && s.id_ra1 == s.ex_wa) || (s.id_use2 && s.id_ra2 == s.ex_wa));
    froz = !m_started || m_err || (m_busy ? !s.dmem_ack : (s.mem_acc && !s.dmem_ack));
    if (froz) begin
      e.en = 4'b0000; e.fl = 2'b00;
    end else if (s.br_taken) begin
      e.en = 4'b1111; e.fl = 2'b11;
    end else if (lu) begin
      e.en = 4'b0011; e.fl = 2'b01;
    end else begin
      e.en = 4'b1111; e.fl = 2'b00;
    end
    e.fa  = m_started ? fwd_ref(s.ex_ra1, s) : 2'b00;
    e.fb  = m_started ? fwd_ref(s.ex_ra2, s) : 2'b00;
    e.req = m_started && !m_err && (m_busy || s.mem_acc);
    e.to  = m_err;
    e.cnt = 16'(m_stall);
    if (chk) q.push_back(e);
    @(posedge clk);
    #1;
    if (m_started && !m_err) begin
      if (m_busy) begin
        if (s.dmem_ack) m_busy = 0;
        else begin
          m_waits++;
          if (m_waits == MEM_TIMEOUT) m_err = 1;
        end
      end else if (s.mem_acc && !s.dmem_ack) begin
        m_busy  = 1;
        m_waits = 0;
      end
    end
    if (!e.en[3] && m_stall < 65535) m_stall++;
    m_started = 1;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_en"}, 32'({bus.en_if, bus.en_id, bus.en_ex, bus.en_mem}), 32'h0);
    check({tag, "_flush"}, 32'({bus.flush_id, bus.flush_ex}), 32'h0);
    check({tag, "_fwd"}, 32'({bus.fwd_a, bus.fwd_b}), 32'h0);
    check({tag, "_req"}, 32'(bus.dmem_req), 32'h0);
    check({tag, "_timeout"}, 32'(bus.mem_timeout), 32'h0);
    check({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'h0);
  endtask

  // Called at posedge+1: assert reset, check it, release, run the startup cycle.
  task automatic reset_and_start(input string tag);
    stim_t s;
    s = zero_stim();
    s.mem_acc = 1; s.mem_we = 1; s.mem_wa = 1; s.ex_ra1 = 1; s.ex_ra2 = 1;
    apply(s);
    rst = 1'b0;
    #1;
    check_all_reset(tag);
    m_started = 0; m_busy = 0; m_err = 0; m_waits = 0; m_stall = 0;
    @(posedge clk);
    #1;
    check_all_reset({tag, "_held"});
    rst = 1'b1;
    step(s, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("en", 32'({bus.en_if, bus.en_id, bus.en_ex, bus.en_mem}), 32'(e.en));
      check("flush", 32'({bus.flush_id, bus.flush_ex}), 32'(e.fl));
      check("fwd_a", 32'(bus.fwd_a), 32'(e.fa));
      check("fwd_b", 32'(bus.fwd_b), 32'(e.fb));
      check("dmem_req", 32'(bus.dmem_req), 32'(e.req));
      check("mem_timeout", 32'(bus.mem_timeout), 32'(e.to));
      check("stall_cnt", 32'(bus.stall_cnt), 32'(e.cnt));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    apply(zero_stim());
    @(posedge clk);
    #1;
    reset_and_start("por");

    // load r3 in EX, ID reads r3: one bubble, then normal
    s = zero_stim();
    s.ex_load = 1; s.ex_we = 1; s.ex_wa = 3; s.id_ra1 = 3; s.id_use1 = 1;
    step(s, 1);
    s.ex_load = 0; s.ex_we = 0; s.ex_wa = 0;
    step(s, 1);

    // load r0: no stall, r0 never forwarded
    s = zero_stim();
    s.ex_load = 1; s.ex_we = 1; s.id_use1 = 1;
    s.mem_we = 1; s.wb_we = 1;
    step(s, 1);

    // MEM beats WB, then WB alone
    s = zero_stim();
    s.mem_we = 1; s.mem_wa = 5; s.wb_we = 1; s.wb_wa = 5; s.ex_ra2 = 5;
    step(s, 1);
    s.mem_we = 0;
    step(s, 1);

    // memory access acknowledged on the fourth cycle
    s = zero_stim();
    s.mem_acc = 1;
    for (int i = 0; i < 3; i++) step(s, 1);
    s.dmem_ack = 1;
    step(s, 1);
    step(zero_stim(), 1);

    for (int i = 0; i < 400; i++) step(rand_stim(), 1);

    // access never acknowledged: timeout, sticky until reset
    reset_and_start("pre_timeout");
    s = zero_stim();
    s.mem_acc = 1;
    for (int i = 0; i < 20; i++) step(s, 1);
    step(zero_stim(), 1);
    reset_and_start("post_err");

    // branch beats load-use, then saturate the stall counter
    s = zero_stim();
    s.ex_load = 1; s.ex_we = 1; s.ex_wa = 2; s.id_ra2 = 2; s.id_use2 = 1; s.br_taken = 1;
    step(s, 1);
    s.br_taken = 0;
    for (int i = 0; i < 70000; i++) step(s, 0);
    step(s, 1);
    check("stall_sat", 32'(bus.stall_cnt), 32'hFFFF);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
